// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the D-stage hazard scoreboard.
// Holds the forward-select encoding, the scoreboard entry layout and the
// default CP0 EPC register number.
package hazard_pkg;

    // Forward-select codes: 0 = register file, k = pipeline stage k after D
    localparam logic [1:0] FW_RF = 2'd0;
    localparam logic [1:0] FW_E  = 2'd1;
    localparam logic [1:0] FW_M  = 2'd2;
    localparam logic [1:0] FW_W  = 2'd3;

    localparam int EPC_ADDR_DEFAULT = 14;

    // Entry field widths. pos is as wide as a forward-select code; tnew is
    // wide enough for any practical Tnew width, narrower values are zero-extended.
    localparam int SB_POS_W  = 2;
    localparam int SB_TNEW_W = 8;

    typedef struct packed {
        logic                 valid;
        logic [SB_POS_W-1:0]  pos;
        logic [SB_TNEW_W-1:0] tnew;
    } sb_entry_t;

    // Remaining-latency countdown that holds at zero
    function automatic logic [SB_TNEW_W-1:0] tnew_dec(input logic [SB_TNEW_W-1:0] t);
        return (t == '0) ? t : t - SB_TNEW_W'(1);
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// md_busy_counter: cycle-counted busy window of the multiply/divide unit.
// A start loads the unit latency; the count then runs down to zero. Busy is
// reported in the start cycle itself and while the count is non-zero.
module md_busy_counter #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o
);

    localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Load on start, otherwise count down and hold at zero
    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = is_div_i ? CW'(DIV_LAT) : CW'(MUL_LAT);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy_o = start_i || (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: stateful D-stage hazard unit. Tracks in-flight GPR
// writers (position and remaining Tnew), the multiply/divide busy window and
// in-flight mtc0 writes to EPC; produces stall, forward selects and the
// resolved D operands.
// Optional build macro HAZ_PERF_CNT_EN adds saturating stall-cause counters.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int DW         = 32,
    parameter int REG_AW     = 5,
    parameter int TW         = 3,
    parameter int FWD_STAGES = 3,
    parameter int MUL_LAT    = 5,
    parameter int DIV_LAT    = 10,
    parameter int EPC_ADDR   = EPC_ADDR_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [REG_AW-1:0]        d_rs,
    input  logic [REG_AW-1:0]        d_rt,
    input  logic [TW-1:0]            d_tuse_rs,
    input  logic [TW-1:0]            d_tuse_rt,
    input  logic [DW-1:0]            d_grs,
    input  logic [DW-1:0]            d_grt,
    input  logic                     d_reg_write,
    input  logic [REG_AW-1:0]        d_a3,
    input  logic [TW-1:0]            d_tnew,
    input  logic                     d_is_mdft,
    input  logic                     d_is_eret,
    input  logic                     d_is_mtc0_epc,
    input  logic                     e_md_start,
    input  logic                     e_md_is_div,
    input  logic                     flush,
    input  logic [FWD_STAGES*DW-1:0] stage_out,
    output logic                     stall,
    output logic [DW-1:0]            d_fw_grs,
    output logic [DW-1:0]            d_fw_grt,
    output logic [1:0]               fw_sel_rs,
    output logic [1:0]               fw_sel_rt
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]              perf_stall_data,
    output logic [31:0]              perf_stall_md,
    output logic [31:0]              perf_stall_eret
`endif
);

    localparam int                  NREG     = 2 ** REG_AW;
    localparam logic [SB_POS_W-1:0] LAST_POS = SB_POS_W'(FWD_STAGES);

    // Parameter sanity: positions must fit a forward-select code, Tnew must
    // fit the entry field, and the EPC number must be a valid CP0 address.
    if (FWD_STAGES < 1 || FWD_STAGES > int'(FW_W)) begin : g_bad_stages
        $error("hazard_scoreboard: FWD_STAGES out of range");
    end
    if (TW > SB_TNEW_W) begin : g_bad_tw
        $error("hazard_scoreboard: TW wider than entry tnew field");
    end
    if (EPC_ADDR < 0 || EPC_ADDR >= NREG) begin : g_bad_epc
        $error("hazard_scoreboard: EPC_ADDR out of range");
    end

    sb_entry_t sb_q [NREG];
    sb_entry_t sb_d [NREG];

    // Bit 0: mtc0-to-EPC sitting in E; bit 1: in M
    logic [1:0] epc_q;
    logic [1:0] epc_d;

    logic hit_rs, hit_rt;
    logic haz_rs, haz_rt;
    logic haz_data, haz_md, haz_eret;
    logic md_busy;
    logic issue;

    md_busy_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_busy (
        .clk      (clk),
        .reset_n  (reset_n),
        .start_i  (e_md_start),
        .is_div_i (e_md_is_div),
        .busy_o   (md_busy)
    );

    // Source lookup: hit, data hazard, forward select and operand mux
    always_comb begin
        hit_rs    = sb_q[d_rs].valid && (d_rs != '0);
        hit_rt    = sb_q[d_rt].valid && (d_rt != '0);
        haz_rs    = hit_rs && (SB_TNEW_W'(d_tuse_rs) < sb_q[d_rs].tnew);
        haz_rt    = hit_rt && (SB_TNEW_W'(d_tuse_rt) < sb_q[d_rt].tnew);
        fw_sel_rs = hit_rs ? sb_q[d_rs].pos : FW_RF;
        fw_sel_rt = hit_rt ? sb_q[d_rt].pos : FW_RF;
        d_fw_grs  = d_grs;
        d_fw_grt  = d_grt;
        for (int k = 1; k <= FWD_STAGES; k++) begin
            if (hit_rs && sb_q[d_rs].pos == SB_POS_W'(k)) begin
                d_fw_grs = stage_out[(k-1)*DW +: DW];
            end
            if (hit_rt && sb_q[d_rt].pos == SB_POS_W'(k)) begin
                d_fw_grt = stage_out[(k-1)*DW +: DW];
            end
        end
    end

    // Stall combination; flush overrides since D and E are being discarded
    always_comb begin
        haz_data = haz_rs || haz_rt;
        haz_md   = d_is_mdft && md_busy;
        haz_eret = d_is_eret && (epc_q != 2'b00);
        stall    = !flush && (haz_data || haz_md || haz_eret);
        issue    = d_reg_write && (d_a3 != '0) && !stall && !flush;
    end

    // Scoreboard advance: age entries, retire at the last stage, kill E on
    // flush, then let a fresh issue overwrite whatever the register held
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            sb_d[i] = sb_q[i];
            if (sb_q[i].valid) begin
                if (sb_q[i].pos == LAST_POS || (flush && sb_q[i].pos == FW_E)) begin
                    sb_d[i] = '0;
                end else begin
                    sb_d[i].pos  = sb_q[i].pos + SB_POS_W'(1);
                    sb_d[i].tnew = tnew_dec(sb_q[i].tnew);
                end
            end
            if (issue && d_a3 == REG_AW'(i)) begin
                sb_d[i].valid = 1'b1;
                sb_d[i].pos   = FW_E;
                sb_d[i].tnew  = SB_TNEW_W'(d_tnew);
            end
        end
    end

    // EPC write tracker: shift E into M, flush drops the E copy
    always_comb begin
        epc_d[0] = d_is_mtc0_epc && !stall && !flush;
        epc_d[1] = epc_q[0] && !flush;
    end

    // State registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                sb_q[i] <= '0;
            end
            epc_q <= 2'b00;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                sb_q[i] <= sb_d[i];
            end
            epc_q <= epc_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] perf_data_q, perf_md_q, perf_eret_q;

    // Saturating per-cause stall counters; flushed cycles are not counted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_data_q <= '0;
            perf_md_q   <= '0;
            perf_eret_q <= '0;
        end else if (!flush) begin
            if (haz_data && perf_data_q != '1) perf_data_q <= perf_data_q + 32'd1;
            if (haz_md   && perf_md_q   != '1) perf_md_q   <= perf_md_q   + 32'd1;
            if (haz_eret && perf_eret_q != '1) perf_eret_q <= perf_eret_q + 32'd1;
        end
    end

    assign perf_stall_data = perf_data_q;
    assign perf_stall_md   = perf_md_q;
    assign perf_stall_eret = perf_eret_q;
`endif

endmodule
